// File: rtl/demux1to8_buf_if.sv
// Bus bundle for the buffered 1-to-8 demultiplexer.
// The producer/consumer side uses the master modport; the demux uses the slave modport.
interface demux1to8_buf_if #(
  parameter int WIDTH   = 32,
  parameter int LANES   = 8,
  parameter int SEL_W   = 3,
  parameter int COUNT_W = 16
);
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic                   busy;
  logic [COUNT_W-1:0]     xfer_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, xfer_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, xfer_cnt
  );
endinterface

// File: rtl/demux1to8_buf.sv
// Buffered 1-to-8 demultiplexer: one incoming word is steered into a
// per-lane one-entry holding register. Lanes buffer independently, so a
// stalled lane never blocks traffic bound for the others.
module demux1to8_buf #(
  parameter int WIDTH   = 32,
  parameter int LANES   = 8,
  parameter int SEL_W   = 3,
  parameter int COUNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  demux1to8_buf_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t        lane_st     [LANES];
  lane_state_t        lane_st_nxt [LANES];
  logic [WIDTH-1:0]   lane_data_p1 [LANES];
  logic [COUNT_W-1:0] cnt_p1;
  logic [LANES-1:0]   vld_p1;
  logic [LANES-1:0]   acc_lane;
  logic               sel_free;
  logic               rdy;
  logic               accept;

  // Selected lane can take a word when empty or when it drains this cycle.
  always_comb begin
    sel_free = (lane_st[bus.in_sel] == EMPTY) | bus.out_ready[bus.in_sel];
    rdy      = rst_n & sel_free;
    accept   = bus.in_valid & rdy;
    acc_lane = accept ? (LANES'(1) << bus.in_sel) : '0;
  end

  // Per-lane next state: accept wins over drain, drain only empties a full lane.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_st_nxt[k] = lane_st[k];
      if (acc_lane[k]) begin
        lane_st_nxt[k] = FULL;
      end else if (lane_st[k] == FULL && bus.out_ready[k]) begin
        lane_st_nxt[k] = EMPTY;
      end
    end
  end

  // Lane state register; reset discards anything held.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (!rst_n) lane_st[k] <= EMPTY;
      else        lane_st[k] <= lane_st_nxt[k];
    end
  end

  // ---- stage p1: lane holding registers, written only on accept ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (!rst_n)           lane_data_p1[k] <= '0;
      else if (acc_lane[k]) lane_data_p1[k] <= bus.in_data;
    end
  end

  // Accepted-transfer counter, wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n)      cnt_p1 <= '0;
    else if (accept) cnt_p1 <= cnt_p1 + COUNT_W'(1);
  end

  // Flatten lane state and data onto the output bus.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      vld_p1[k] = (lane_st[k] == FULL);
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign bus.out_data[g*WIDTH +: WIDTH] = lane_data_p1[g];
    end
  endgenerate

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_p1;
  assign bus.busy      = |vld_p1;
  assign bus.xfer_cnt  = cnt_p1;

endmodule

// File: tb/tb_demux1to8_buf.sv
// Testbench for demux1to8_buf: directed scenarios plus randomized traffic,
// compared against a lane-array reference model. A second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_demux1to8_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux1to8_buf_if #(.WIDTH(32), .LANES(8), .SEL_W(3), .COUNT_W(16)) bif ();
  demux1to8_buf_if #(.WIDTH(32), .LANES(8), .SEL_W(3), .COUNT_W(4))  sif ();

  demux1to8_buf #(.WIDTH(32), .LANES(8), .SEL_W(3), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );
  demux1to8_buf #(.WIDTH(32), .LANES(8), .SEL_W(3), .COUNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave)
  );

  assign sif.in_data   = bif.in_data;
  assign sif.in_sel    = bif.in_sel;
  assign sif.in_valid  = bif.in_valid;
  assign sif.out_ready = bif.out_ready;

  int ncmp = 0;
  int nbad = 0;

  // Reference model: one valid flag and one data word per lane, plus a count.
  bit          mv [8];
  logic [31:0] md [8];
  int unsigned mcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_vld();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mv[k];
    return v;
  endfunction

  // One clock cycle: apply inputs, check in_ready, advance model, check outputs.
  task automatic tick(input logic rn, input logic v, input logic [2:0] s,
                      input logic [31:0] d, input logic [7:0] r);
    logic exp_rdy;
    logic acc;
    rst_n         = rn;
    bif.in_valid  = v;
    bif.in_sel    = s;
    bif.in_data   = d;
    bif.out_ready = r;
    #2;
    exp_rdy = rn && (!mv[s] || r[s]);
    chk("in_ready", bif.in_ready, exp_rdy);
    if (!rn) begin
      for (int k = 0; k < 8; k++) begin mv[k] = 0; md[k] = '0; end
      mcnt = 0;
    end else begin
      acc = v && exp_rdy;
      for (int k = 0; k < 8; k++) if (mv[k] && r[k]) mv[k] = 0;
      if (acc) begin
        mv[s] = 1;
        md[s] = d;
        mcnt++;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", bif.out_valid, model_vld());
    chk("busy", bif.busy, (model_vld() != 8'h00));
    chk("xfer_cnt", bif.xfer_cnt, mcnt % 65536);
    chk("xfer_cnt4", sif.xfer_cnt, mcnt % 16);
    for (int k = 0; k < 8; k++)
      chk($sformatf("lane%0d_data", k), bif.out_data[k*32 +: 32], md[k]);
  endtask

  initial begin
    mcnt = 0;
    for (int k = 0; k < 8; k++) begin mv[k] = 0; md[k] = '0; end

    // T1: reset held two cycles while a word is offered
    tick(1'b0, 1'b1, 3'd3, 32'hA5A5A5A5, 8'h00);
    tick(1'b0, 1'b1, 3'd3, 32'hA5A5A5A5, 8'h00);
    chk("t1_vld", bif.out_valid, 8'h00);
    chk("t1_cnt", bif.xfer_cnt, 16'd0);
    chk("t1_data", bif.out_data[255:192], 64'd0);

    // T2: single route to lane 5, hold, then drain
    tick(1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 8'h00);
    chk("t2_vld", bif.out_valid, 8'h20);
    chk("t2_lane5", bif.out_data[5*32 +: 32], 32'hDEADBEEF);
    chk("t2_cnt", bif.xfer_cnt, 16'd1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 3'($urandom), $urandom, 8'h00);
    chk("t2_hold", bif.out_data[5*32 +: 32], 32'hDEADBEEF);
    tick(1'b1, 1'b0, 3'd0, 32'h0, 8'h20);
    chk("t2_drain", bif.out_valid, 8'h00);

    // T3: back-pressure on lane 2, other lane still accepted
    tick(1'b1, 1'b1, 3'd2, 32'hCAFE0002, 8'h00);
    tick(1'b1, 1'b1, 3'd2, 32'h00001234, 8'h00);
    chk("t3_lane2", bif.out_data[2*32 +: 32], 32'hCAFE0002);
    chk("t3_cnt", bif.xfer_cnt, 16'd2);
    tick(1'b1, 1'b1, 3'd6, 32'h66666666, 8'h00);
    chk("t3_vld", bif.out_valid, 8'h44);

    // T4: full throughput into lane 1 with drain held high
    tick(1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 3'd1, 32'(i), 8'h02);
      chk("t4_lane1", bif.out_data[1*32 +: 32], 32'(i));
    end
    chk("t4_cnt", bif.xfer_cnt, 16'd8);

    // T5: counter wrap on the 4-bit instance
    tick(1'b0, 1'b0, 3'd0, 32'h0, 8'hFF);
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 1'b1, 3'(i % 8), $urandom, 8'hFF);
      if (i == 14) chk("t5_cnt15", sif.xfer_cnt, 4'd15);
      if (i == 15) chk("t5_cnt0", sif.xfer_cnt, 4'd0);
      if (i == 16) chk("t5_cnt1", sif.xfer_cnt, 4'd1);
    end

    // T6: reset in the middle of operation discards held words
    tick(1'b1, 1'b1, 3'd0, 32'h10, 8'h00);
    tick(1'b1, 1'b1, 3'd3, 32'h13, 8'h00);
    tick(1'b1, 1'b1, 3'd7, 32'h17, 8'h00);
    tick(1'b0, 1'b1, 3'd4, 32'h14, 8'hFF);
    chk("t6_vld", bif.out_valid, 8'h00);
    chk("t6_busy", bif.busy, 1'b0);
    chk("t6_cnt", bif.xfer_cnt, 16'd0);
    tick(1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 8'h00);
    chk("t6_vld2", bif.out_valid, 8'h20);
    chk("t6_cnt2", bif.xfer_cnt, 16'd1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           3'($urandom), $urandom, 8'($urandom & $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
